// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: 2-entry elastic buffer with valid/ready on both sides,
// flush, write-back data select, forwarding tap and a saturating stall counter.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_MemtoReg,
  input  logic              in_RegWrite,
  input  logic [REG_AW-1:0] in_WriteReg,
  input  logic [DATA_W-1:0] in_ReadData,
  input  logic [DATA_W-1:0] in_ALUResult,
  output logic              O_valid,
  input  logic              out_ready,
  output logic              O_MemtoReg,
  output logic              O_RegWrite,
  output logic [REG_AW-1:0] O_WriteReg,
  output logic [DATA_W-1:0] O_ReadData,
  output logic [DATA_W-1:0] O_ALUResult,
  output logic [DATA_W-1:0] O_WBData,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Entry layout, MSB first: {MemtoReg, RegWrite, WriteReg, ReadData, ALUResult}
  localparam int unsigned ENTRY_W = 2 + REG_AW + 2 * DATA_W;
  localparam int unsigned RD_LSB  = DATA_W;
  localparam int unsigned WR_LSB  = 2 * DATA_W;

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [ENTRY_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic [ENTRY_W-1:0] in_entry;
  logic               push;
  logic               pop;

  assign in_entry = {in_MemtoReg, in_RegWrite, in_WriteReg, in_ReadData, in_ALUResult};

  // Handshake status depends on registered occupancy only
  assign in_ready = (cnt_q != 2'd2);
  assign O_valid  = (cnt_q != 2'd0);
  assign push     = in_valid & in_ready;
  assign pop      = O_valid & out_ready;

  // Next-state: buffer pointers, occupancy, head-entry outputs and stall counter
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    stall_d  = stall_q;

    if (flush) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[tail_q] = in_entry;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 2'd1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 2'd1;
      end
      // Head outputs follow the new head; they hold their last value when empty
      if (cnt_d != 2'd0) begin
        out_d = mem_d[head_d];
      end
    end

    if (!flush && O_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State register: whole pipeline advances on the falling edge
  always_ff @(negedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
      out_q    <= '0;
      stall_q  <= '0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      stall_q  <= stall_d;
    end
  end

  assign O_MemtoReg  = out_q[ENTRY_W-1];
  assign O_RegWrite  = out_q[ENTRY_W-2];
  assign O_WriteReg  = out_q[WR_LSB +: REG_AW];
  assign O_ReadData  = out_q[RD_LSB +: DATA_W];
  assign O_ALUResult = out_q[0 +: DATA_W];

  assign O_WBData  = O_MemtoReg ? O_ReadData : O_ALUResult;
  assign fwd_valid = O_valid & O_RegWrite;
  assign fwd_addr  = O_WriteReg;
  assign fwd_data  = O_WBData;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: directed stimulus queues expected entries,
// a posedge monitor checks every entry the write-back side accepts.
module tb_mem_wb_pipe;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic              mtr;
    logic              rw;
    logic [REG_AW-1:0] wr;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_MemtoReg;
  logic              in_RegWrite;
  logic [REG_AW-1:0] in_WriteReg;
  logic [DATA_W-1:0] in_ReadData;
  logic [DATA_W-1:0] in_ALUResult;
  logic              O_valid;
  logic              out_ready;
  logic              O_MemtoReg;
  logic              O_RegWrite;
  logic [REG_AW-1:0] O_WriteReg;
  logic [DATA_W-1:0] O_ReadData;
  logic [DATA_W-1:0] O_ALUResult;
  logic [DATA_W-1:0] O_WBData;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  stall_cnt;

  int   total;
  int   bad;
  ent_t sb[$];
  ent_t mon_e;
  logic [DATA_W-1:0] mon_wb;

  mem_wb_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite), .in_WriteReg(in_WriteReg),
    .in_ReadData(in_ReadData), .in_ALUResult(in_ALUResult),
    .O_valid(O_valid), .out_ready(out_ready),
    .O_MemtoReg(O_MemtoReg), .O_RegWrite(O_RegWrite), .O_WriteReg(O_WriteReg),
    .O_ReadData(O_ReadData), .O_ALUResult(O_ALUResult), .O_WBData(O_WBData),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic m, input logic r, input logic [REG_AW-1:0] w,
                              input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] a);
    ent_t e;
    e.mtr = m; e.rw = r; e.wr = w; e.rd = d; e.alu = a;
    return e;
  endfunction

  task automatic drive(input ent_t e);
    in_MemtoReg  = e.mtr;
    in_RegWrite  = e.rw;
    in_WriteReg  = e.wr;
    in_ReadData  = e.rd;
    in_ALUResult = e.alu;
  endtask

  // Advance past the active (falling) edge and settle
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor: an entry is consumed on the next falling edge when valid & ready
  always @(posedge clk) begin
    if (!rst && !flush && O_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got entry alu=%0h want no entry", O_ALUResult);
      end else begin
        mon_e  = sb.pop_front();
        mon_wb = mon_e.mtr ? mon_e.rd : mon_e.alu;
        chk("mon_head",
            128'({O_MemtoReg, O_RegWrite, O_WriteReg, O_ReadData, O_ALUResult, O_WBData,
                  fwd_valid, fwd_addr, fwd_data}),
            128'({mon_e.mtr, mon_e.rw, mon_e.wr, mon_e.rd, mon_e.alu, mon_wb,
                  mon_e.rw, mon_e.wr, mon_wb}));
      end
    end
  end

  initial begin
    ent_t e;
    total = 0;
    bad   = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(1'b0, 1'b0, 3'd0, 16'h0, 16'h0));
    tick();
    chk("rst_o_valid", 128'(O_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_fields", 128'({O_MemtoReg, O_RegWrite, O_WriteReg, O_ReadData, O_ALUResult}), 128'(0));
    chk("rst_wb_fwd", 128'({O_WBData, fwd_valid, fwd_addr, fwd_data}), 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    rst = 1'b0;

    // Reset then stream
    e = mk(1'b1, 1'b1, 3'd5, 16'hA5A5, 16'h0011);
    drive(e); sb.push_back(e); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("s1_valid", 128'(O_valid), 128'(1));
    chk("s1_wbdata", 128'(O_WBData), 128'(16'hA5A5));
    chk("s1_fwd", 128'({fwd_valid, fwd_addr}), 128'({1'b1, 3'd5}));
    e = mk(1'b0, 1'b1, 3'd2, 16'hBEEF, 16'h1234);
    drive(e); sb.push_back(e);
    tick();
    chk("s2_wbdata", 128'(O_WBData), 128'(16'h1234));
    in_valid = 1'b0;
    tick();
    chk("s3_empty", 128'(O_valid), 128'(0));
    chk("s3_hold", 128'(O_WBData), 128'(16'h1234));
    chk("s3_fwd_off", 128'(fwd_valid), 128'(0));
    chk("s3_stall", 128'(stall_cnt), 128'(0));

    // Backpressure fill
    out_ready = 1'b0;
    e = mk(1'b0, 1'b1, 3'd1, 16'hC0C0, 16'h0C0C);
    drive(e); sb.push_back(e); in_valid = 1'b1;
    tick();
    chk("bp1_ready", 128'({in_ready, stall_cnt}), 128'({1'b1, 4'd0}));
    e = mk(1'b1, 1'b0, 3'd3, 16'hD00D, 16'h0DDD);
    drive(e); sb.push_back(e);
    tick();
    chk("bp2_ready", 128'({in_ready, stall_cnt}), 128'({1'b0, 4'd1}));
    drive(mk(1'b1, 1'b1, 3'd7, 16'hEEEE, 16'hE0E0));
    tick();
    chk("bp3_ready", 128'({in_ready, stall_cnt}), 128'({1'b0, 4'd2}));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp4_head", 128'({O_valid, O_WBData, fwd_valid}), 128'({1'b1, 16'hD00D, 1'b0}));
    tick();
    chk("bp5_empty", 128'({O_valid, in_ready, stall_cnt}), 128'({1'b1, 1'b1, 4'd2} >> 0 & 0) | 128'({1'b0, 1'b1, 4'd2}));

    // Simultaneous push/pop at count 1
    e = mk(1'b0, 1'b1, 3'd0, 16'h1000, 16'h2000);
    drive(e); sb.push_back(e); in_valid = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      e = mk(1'(i & 1), 1'b1, 3'(i), 16'(16'h1000 + i), 16'(16'h2000 + i));
      drive(e); sb.push_back(e);
      tick();
      chk("pp_state", 128'({O_valid, in_ready, O_ALUResult}), 128'({1'b1, 1'b1, 16'(16'h2000 + i)}));
    end
    in_valid = 1'b0;
    tick();
    chk("pp_drained", 128'(O_valid), 128'(0));

    // Flush with count 2 while a new entry is offered
    out_ready = 1'b0;
    e = mk(1'b1, 1'b1, 3'd4, 16'h4444, 16'h0444);
    drive(e); sb.push_back(e); in_valid = 1'b1;
    tick();
    e = mk(1'b0, 1'b1, 3'd6, 16'h6666, 16'h0666);
    drive(e); sb.push_back(e);
    tick();
    chk("fl_full", 128'({in_ready, stall_cnt}), 128'({1'b0, 4'd3}));
    flush = 1'b1; out_ready = 1'b1;
    drive(mk(1'b1, 1'b1, 3'd7, 16'h7777, 16'h0777));
    tick();
    sb.delete();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_after", 128'({O_valid, in_ready, stall_cnt}), 128'({1'b0, 1'b1, 4'd3}));
    tick();
    chk("fl_absent", 128'(O_valid), 128'(0));
    e = mk(1'b1, 1'b1, 3'd2, 16'h2B2B, 16'h0002);
    drive(e); sb.push_back(e); in_valid = 1'b1;
    tick();
    chk("fl_restart", 128'({O_valid, O_WBData, fwd_addr}), 128'({1'b1, 16'h2B2B, 3'd2}));
    in_valid = 1'b0;
    tick();
    chk("fl_restart_empty", 128'(O_valid), 128'(0));

    // Stall counter saturation, then reset
    out_ready = 1'b0;
    e = mk(1'b0, 1'b1, 3'd1, 16'h5555, 16'h0555);
    drive(e); sb.push_back(e); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) chk("sat_mid", 128'(stall_cnt), 128'(4'd9));
    end
    chk("sat_top", 128'(stall_cnt), 128'(4'd15));
    rst = 1'b1;
    tick();
    sb.delete();
    rst = 1'b0;
    chk("sat_rst", 128'({stall_cnt, O_valid, in_ready}), 128'({4'd0, 1'b0, 1'b1}));
    chk("sat_rst_out", 128'({O_WBData, O_WriteReg, fwd_valid}), 128'(0));

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
